imm_encoder: RTL and testbench

- Instruction encoder: the inverse of the pipeline's immediate decoder. It packs an operation request (kind, registers, funct3, 64-bit immediate) into 32-bit RV64 instruction words.
- Expands the LI pseudo-op into an ADDI, or into a LUI followed by an optional ADDIW.
- Used by the boot/patch sequencer to generate code into instruction memory.
- Valid/ready on both sides, one output register, 1-cycle latency.

---
 rtl/imm_encoder_if.sv | 32 +++
 rtl/imm_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_imm_encoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// Request/instruction handshake bundle for imm_encoder.
// master: the code generator driving requests and taking instruction beats.
// slave:  the encoder itself.
interface imm_encoder_if #(
    parameter int unsigned IMM_W = 64
) ();
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_kind;
    logic [4:0]       req_rd;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [2:0]       req_funct3;
    logic [IMM_W-1:0] req_imm;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst_32;
    logic             inst_last;
    logic             err_range;

    modport master (
        output req_valid, req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_imm,
        output inst_ready,
        input  req_ready, inst_valid, inst_32, inst_last, err_range
    );

    modport slave (
        input  req_valid, req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_imm,
        input  inst_ready,
        output req_ready, inst_valid, inst_32, inst_last, err_range
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs an operation request into 32-bit RV64 instruction words,
// expanding LI into ADDI or LUI (+ optional ADDIW). One output register,
// one cycle from accept to inst_valid.
// Optional feature macro: IMMENC_RANGE_CHECK_EN enables immediate range and
// alignment checking (err_range); when undefined, immediates are truncated.
module imm_encoder #(
    parameter int unsigned IMM_W = 64
) (
    input logic          clk,
    input logic          rst,
    imm_encoder_if.slave bus
);

`ifdef IMMENC_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_CUST0 = 7'b0001011;

    // Immediate bits a shift is allowed to carry: shamt[5:0] and the arith bit.
    localparam logic [IMM_W-1:0] SHIFT_MASK = {{(IMM_W-11){1'b0}}, 11'h43F};

    typedef enum logic [2:0] {
        K_I_ALU   = 3'd0,
        K_LOAD    = 3'd1,
        K_STORE   = 3'd2,
        K_BRANCH  = 3'd3,
        K_LUI     = 3'd4,
        K_AUIPC   = 3'd5,
        K_CUSTOM0 = 3'd6,
        K_LI      = 3'd7
    } kind_t;

    typedef enum logic [1:0] {
        IDLE,
        OUT,
        OUT1
    } state_t;

    state_t           state, state_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      beat2_q, beat2_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             ready;
    logic             accept;

    kind_t            kind;
    logic [IMM_W-1:0] imm;
    logic [4:0]       rd, rs1, rs2;
    logic [2:0]       f3;
    logic             fits12, fits13, fits32;
    logic [19:0]      li_hi;

    logic [31:0]      enc_inst;
    logic [31:0]      enc_beat2;
    logic             enc_two;
    logic             enc_err;
    logic             bad;

    assign kind = kind_t'(bus.req_kind);
    assign imm  = bus.req_imm;
    assign rd   = bus.req_rd;
    assign rs1  = bus.req_rs1;
    assign rs2  = bus.req_rs2;
    assign f3   = bus.req_funct3;

    assign fits12 = (imm == {{(IMM_W-12){imm[11]}}, imm[11:0]});
    assign fits13 = (imm == {{(IMM_W-13){imm[12]}}, imm[12:0]});
    assign fits32 = (imm == {{(IMM_W-32){imm[31]}}, imm[31:0]});

    // (imm[31:0] + 0x800)[31:12]: the low-half add only contributes a carry,
    // which is exactly imm[11].
    assign li_hi = imm[31:12] + {19'd0, imm[11]};

    // Encode the presented request into its first beat, optional second beat and error flag.
    always_comb begin
        enc_inst  = '0;
        enc_beat2 = '0;
        enc_two   = 1'b0;
        bad       = 1'b0;
        case (kind)
            K_I_ALU: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    enc_inst = {1'b0, imm[10], 4'b0000, imm[5:0], rs1, f3, rd, OP_IMM};
                    bad      = |(imm & ~SHIFT_MASK);
                end else begin
                    enc_inst = {imm[11:0], rs1, f3, rd, OP_IMM};
                    bad      = !fits12;
                end
            end
            K_LOAD: begin
                enc_inst = {imm[11:0], rs1, f3, rd, OP_LOAD};
                bad      = !fits12;
            end
            K_CUSTOM0: begin
                enc_inst = {imm[11:0], rs1, f3, rd, OP_CUST0};
                bad      = !fits12;
            end
            K_STORE: begin
                enc_inst = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
                bad      = !fits12;
            end
            K_BRANCH: begin
                enc_inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
                bad      = !fits13 || imm[0];
            end
            K_LUI: begin
                enc_inst = {imm[31:12], rd, OP_LUI};
                bad      = !fits32 || (imm[11:0] != 12'd0);
            end
            K_AUIPC: begin
                enc_inst = {imm[31:12], rd, OP_AUIPC};
                bad      = !fits32 || (imm[11:0] != 12'd0);
            end
            K_LI: begin
                bad = !fits32;
                if (fits12) begin
                    enc_inst = {imm[11:0], 5'd0, 3'b000, rd, OP_IMM};
                end else begin
                    enc_inst  = {li_hi, rd, OP_LUI};
                    enc_beat2 = {imm[11:0], rd, 3'b000, rd, OP_IMM32};
                    enc_two   = (imm[11:0] != 12'd0);
                end
            end
        endcase
        enc_err = bad & RANGE_CHECK;
        if (enc_err) begin
            enc_inst = '0;
            enc_two  = 1'b0;
        end
    end

    assign accept = bus.req_valid & ready;

    // Next-state and output-register loading for the IDLE/OUT/OUT1 sequencer.
    always_comb begin
        state_d = state;
        inst_d  = inst_q;
        beat2_d = beat2_q;
        last_d  = last_q;
        err_d   = err_q;
        ready   = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            OUT:  ready = bus.inst_ready;
            OUT1: ready = 1'b0;
            default: ready = 1'b0;
        endcase
        if (state == OUT && bus.inst_ready) begin
            state_d = IDLE;
        end
        if (state == OUT1 && bus.inst_ready) begin
            state_d = OUT;
            inst_d  = beat2_q;
            last_d  = 1'b1;
            err_d   = 1'b0;
        end
        if (bus.req_valid && ready) begin
            state_d = enc_two ? OUT1 : OUT;
            inst_d  = enc_inst;
            beat2_d = enc_beat2;
            last_d  = !enc_two;
            err_d   = enc_err;
        end
    end

    // State and output register, cleared asynchronously (drops any pending second beat).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            inst_q  <= '0;
            beat2_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            inst_q  <= inst_d;
            beat2_q <= beat2_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.inst_valid = (state != IDLE);
    assign bus.inst_32    = inst_q;
    assign bus.inst_last  = last_q;
    assign bus.err_range  = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed requests, a field-level reference model
// feeding an expected-beat queue, and one negedge compare process.
module tb_imm_encoder;

`ifdef IMMENC_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imm_encoder_if #(.IMM_W(64)) bus ();

    imm_encoder #(.IMM_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] inst;
        bit          last;
        bit          err;
    } beat_t;

    typedef struct {
        int     kind;
        int     rd;
        int     rs1;
        int     rs2;
        int     f3;
        longint imm;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[$];
    int    total = 0;
    int    bad = 0;
    int    run = 0;
    int    max_run = 0;
    bit    toggle = 1'b0;
    bit    rdy_hold = 1'b1;

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_range(longint v, int bits);
        longint lim = longint'(1) <<< (bits - 1);
        return (v >= -lim) && (v < lim);
    endfunction

    function automatic logic [31:0] ifmt(longint imm12, int rs1, int f3, int rd, int op);
        longint r;
        r = ((imm12 & 64'hFFF) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12)
            | (longint'(rd) << 7) | longint'(op);
        return r[31:0];
    endfunction

    // Reference: what the request must produce, from the ISA field rules.
    function automatic int model(int kind, int rd, int rs1, int rs2, int f3, longint imm,
                                 output beat_t b0, output beat_t b1);
        longint r = 0;
        longint lo, hi;
        bit     err = 1'b0;
        int     n = 1;
        int     op;
        b0 = '{32'd0, 1'b1, 1'b0};
        b1 = '{32'd0, 1'b1, 1'b0};
        case (kind)
            0, 1, 6: begin
                op = (kind == 0) ? 'h13 : (kind == 1) ? 'h03 : 'h0B;
                if (kind == 0 && (f3 == 1 || f3 == 5)) begin
                    err = (imm & ~64'h43F) != 0;
                    r   = ifmt(imm & 64'h43F, rs1, f3, rd, op);
                end else begin
                    err = !in_range(imm, 12);
                    r   = ifmt(imm, rs1, f3, rd, op);
                end
            end
            2: begin
                err = !in_range(imm, 12);
                r = (((imm >> 5) & 64'h7F) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15)
                    | (longint'(f3) << 12) | ((imm & 64'h1F) << 7) | 64'h23;
            end
            3: begin
                err = !in_range(imm, 13) || ((imm & 64'h1) != 0);
                r = (((imm >> 12) & 64'h1) << 31) | (((imm >> 5) & 64'h3F) << 25)
                    | (longint'(rs2) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12)
                    | (((imm >> 1) & 64'hF) << 8) | (((imm >> 11) & 64'h1) << 7) | 64'h63;
            end
            4, 5: begin
                err = !in_range(imm, 32) || ((imm & 64'hFFF) != 0);
                r = (imm & 64'hFFFFF000) | (longint'(rd) << 7) | ((kind == 4) ? 64'h37 : 64'h17);
            end
            default: begin
                err = !in_range(imm, 32);
                if (in_range(imm, 12)) begin
                    r = ifmt(imm, 0, 0, rd, 'h13);
                end else begin
                    lo = ((imm & 64'hFFF) ^ 64'h800) - 64'h800;
                    hi = ((imm - lo) >> 12) & 64'hFFFFF;
                    r  = (hi << 12) | (longint'(rd) << 7) | 64'h37;
                    if (lo != 0) begin
                        n = 2;
                        b1.inst = ifmt(lo, rd, 0, rd, 'h1B);
                    end
                end
            end
        endcase
        if (CHK && err) begin
            b0 = '{32'd0, 1'b1, 1'b1};
            n  = 1;
        end else begin
            b0.inst = r[31:0];
            b0.last = (n == 1);
        end
        return n;
    endfunction

    // Compare process: outputs against the expected-beat queue every cycle.
    always @(negedge clk) begin
        beat_t m0, m1;
        int    mn;
        if (rst) begin
            exp_q.delete();
            run = 0;
            check1("rst_valid", bus.inst_valid, 1'b0);
            check1("rst_req_ready", bus.req_ready, 1'b1);
            check32("rst_inst", bus.inst_32, 32'd0);
            check1("rst_last", bus.inst_last, 1'b0);
            check1("rst_err", bus.err_range, 1'b0);
        end else begin
            check1("inst_valid", bus.inst_valid, exp_q.size() != 0);
            check1("req_ready", bus.req_ready,
                   (exp_q.size() == 0) || (bus.inst_ready && exp_q[0].last));
            if (exp_q.size() != 0) begin
                check32("inst_32", bus.inst_32, exp_q[0].inst);
                check1("inst_last", bus.inst_last, exp_q[0].last);
                check1("err_range", bus.err_range, exp_q[0].err);
                if (bus.inst_ready) begin
                    void'(exp_q.pop_front());
                    run++;
                end else begin
                    run = 0;
                end
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
            if (bus.req_valid && bus.req_ready) begin
                mn = model(int'(bus.req_kind), int'(bus.req_rd), int'(bus.req_rs1),
                           int'(bus.req_rs2), int'(bus.req_funct3), longint'(bus.req_imm), m0, m1);
                exp_q.push_back(m0);
                if (mn == 2) exp_q.push_back(m1);
            end
        end
    end

    // Consumer ready: held level or toggling every cycle.
    initial begin
        bus.inst_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.inst_ready = toggle ? !bus.inst_ready : rdy_hold;
        end
    end

    task automatic send(int kind, int rd, int rs1, int rs2, int f3, longint imm);
        int t = 0;
        bus.req_kind   = 3'(kind);
        bus.req_rd     = 5'(rd);
        bus.req_rs1    = 5'(rs1);
        bus.req_rs2    = 5'(rs2);
        bus.req_funct3 = 3'(f3);
        bus.req_imm    = imm;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= 100) begin
            bad++;
            $display("FAIL send_timeout: req_ready stuck low, want accept within 100 cycles");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, want 0", exp_q.size());
        end
    endtask

    function automatic void add(int k, int rd, int rs1, int rs2, int f3, longint imm);
        vec_t v;
        v = '{k, rd, rs1, rs2, f3, imm};
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b0, b1;
        int    n;

        bus.req_valid  = 1'b0;
        bus.req_kind   = '0;
        bus.req_rd     = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_funct3 = '0;
        bus.req_imm    = '0;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Hand-computed anchors for the model.
        n = model(7, 5, 0, 0, 0, 64'h12345678, b0, b1);
        check32("pin_li_big_n", 32'(n), 32'd2);
        check32("pin_li_big_b0", b0.inst, 32'h123452B7);
        check1("pin_li_big_b0_last", b0.last, 1'b0);
        check32("pin_li_big_b1", b1.inst, 32'h6782829B);
        n = model(7, 1, 0, 0, 0, -64'sd1, b0, b1);
        check32("pin_li_m1", b0.inst, 32'hFFF00093);
        n = model(7, 10, 0, 0, 0, 64'h800, b0, b1);
        check32("pin_li_800_b0", b0.inst, 32'h00001537);
        check32("pin_li_800_b1", b1.inst, 32'h8005051B);
        n = model(7, 10, 0, 0, 0, 64'h5000, b0, b1);
        check32("pin_li_5000_n", 32'(n), 32'd1);
        check32("pin_li_5000", b0.inst, 32'h00005537);
        n = model(3, 0, 1, 2, 0, 64'd8, b0, b1);
        check32("pin_br8", b0.inst, 32'h00208463);
        n = model(3, 0, 1, 2, 0, 64'd7, b0, b1);
`ifdef IMMENC_RANGE_CHECK_EN
        check32("pin_br7", b0.inst, 32'h00000000);
        check1("pin_br7_err", b0.err, 1'b1);
`else
        check32("pin_br7", b0.inst, 32'h00208363);
        check1("pin_br7_err", b0.err, 1'b0);
`endif

        add(7, 5, 0, 0, 0, 64'h12345678);
        add(7, 1, 0, 0, 0, -64'sd1);
        add(7, 10, 0, 0, 0, 64'h800);
        add(7, 10, 0, 0, 0, 64'h5000);
        add(7, 0, 0, 0, 0, 64'h7FFFFFFF);
        add(7, 3, 0, 0, 0, -64'sd2048);
        add(7, 3, 0, 0, 0, -64'sd2049);
        add(7, 4, 0, 0, 0, 64'h100000000);
        add(3, 0, 1, 2, 0, 64'd8);
        add(3, 0, 1, 2, 0, 64'd7);
        add(3, 0, 3, 4, 1, -64'sd4096);
        add(3, 0, 3, 4, 5, 64'd4096);
        add(3, 0, 1, 1, 0, 64'hFFE);
        add(0, 7, 8, 0, 0, -64'sd5);
        add(0, 7, 8, 0, 1, 64'd3);
        add(0, 7, 8, 0, 5, 64'h403);
        add(0, 7, 8, 0, 1, 64'h40);
        add(0, 2, 2, 0, 4, 64'd2047);
        add(1, 9, 2, 0, 3, -64'sd2048);
        add(1, 9, 2, 0, 2, 64'd2048);
        add(2, 0, 2, 11, 3, -64'sd4);
        add(2, 0, 2, 11, 2, 64'h7FF);
        add(4, 6, 0, 0, 0, 64'h12345000);
        add(4, 6, 0, 0, 0, 64'h12345001);
        add(5, 6, 0, 0, 0, -64'sd4096);
        add(4, 6, 0, 0, 0, 64'h80000000);
        add(6, 31, 31, 0, 7, 64'h123);

        foreach (vecs[i]) send(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                               vecs[i].f3, vecs[i].imm);
        drain();

        // Back-to-back single-beat loads must stream one beat per cycle.
        max_run = 0;
        for (int i = 0; i < 4; i++) send(1, i + 1, 2, 0, 3, longint'(i * 8));
        drain();
        check1("b2b_four_consecutive", max_run >= 4, 1'b1);

        // Backpressure on the first LI beat.
        rdy_hold = 1'b0;
        @(posedge clk);
        #2;
        send(7, 5, 0, 0, 0, 64'h12345678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("bp_hold_inst", bus.inst_32, 32'h123452B7);
            check1("bp_req_ready", bus.req_ready, 1'b0);
        end
        rdy_hold = 1'b1;
        drain();

        // Same vectors with a toggling consumer.
        toggle = 1'b1;
        foreach (vecs[i]) send(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                               vecs[i].f3, vecs[i].imm);
        toggle = 1'b0;
        drain();

        // Reset while beat 1 of a two-beat LI is presented.
        rdy_hold = 1'b0;
        @(posedge clk);
        #2;
        send(7, 5, 0, 0, 0, 64'h12345678);
        @(negedge clk);
        check32("pre_rst_beat1", bus.inst_32, 32'h123452B7);
        #2 rst = 1'b1;
        #1;
        check1("async_rst_valid", bus.inst_valid, 1'b0);
        check1("async_rst_ready", bus.req_ready, 1'b1);
        check32("async_rst_inst", bus.inst_32, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_hold = 1'b1;
        repeat (6) @(negedge clk);
        check1("post_rst_no_beat", bus.inst_valid, 1'b0);

        send(7, 1, 0, 0, 0, -64'sd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
